// File: rtl/lgu_pkg.sv
// Shared types and the bitwise evaluation function for the multi-input logic gate unit.
package lgu_pkg;

   localparam int STAT_W = 32;
   localparam int MAX_W  = 64;
   localparam int MAX_N  = 8;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NAND = 3'd2,
      OP_NOR  = 3'd3,
      OP_XOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOT  = 3'd6,
      OP_ILL  = 3'd7
   } op_e;

   // Operands are laid out on a fixed MAX_W pitch so one function serves every WIDTH/N_IN.
   // Only the first n_in slots take part; OP_NOT uses slot 0 alone.
   function automatic logic [MAX_W-1:0] lgu_eval(
      input op_e                      op,
      input logic [MAX_N*MAX_W-1:0]   operands,
      input int                       n_in
   );
      logic [MAX_W-1:0] r_and;
      logic [MAX_W-1:0] r_or;
      logic [MAX_W-1:0] r_xor;
      logic [MAX_W-1:0] res;
      r_and = '1;
      r_or  = '0;
      r_xor = '0;
      for (int k = 0; k < MAX_N; k++) begin
         if (k < n_in) begin
            r_and = r_and & operands[k*MAX_W +: MAX_W];
            r_or  = r_or  | operands[k*MAX_W +: MAX_W];
            r_xor = r_xor ^ operands[k*MAX_W +: MAX_W];
         end
      end
      case (op)
         OP_AND:  res = r_and;
         OP_OR:   res = r_or;
         OP_NAND: res = ~r_and;
         OP_NOR:  res = ~r_or;
         OP_XOR:  res = r_xor;
         OP_XNOR: res = ~r_xor;
         OP_NOT:  res = ~operands[MAX_W-1:0];
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lgu_pipe_stage.sv
// One elastic valid/ready register slice; payload only loads on an accepted beat.
module lgu_pipe_stage #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/logic_gate_unit.sv
// Two-stage pipelined N-input bitwise gate with runtime op select.
// Optional LGU_STATS_EN adds a saturating output-handshake counter on stat_ops.
module logic_gate_unit
   import lgu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_IN  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_op,
   input  logic [N_IN*WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_err
`ifdef LGU_STATS_EN
   ,
   output logic [STAT_W-1:0]     stat_ops
`endif
);

   localparam int S1_W = 3 + N_IN*WIDTH;
   localparam int S2_W = 1 + WIDTH;

   logic                   s1_valid;
   logic [S1_W-1:0]        s1_data;
   logic                   s2_ready;
   logic [S2_W-1:0]        s2_in_data;
   logic [S2_W-1:0]        s2_data;
   logic [MAX_N*MAX_W-1:0] ops_pad;
   logic [MAX_W-1:0]       res_full;
   logic [MAX_W:0]         unused_res;
   op_e                    s1_op;

   lgu_pipe_stage #(.DW(S1_W)) u_stage1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_op, in_data}),
      .out_valid (s1_valid),
      .out_ready (s2_ready),
      .out_data  (s1_data)
   );

   assign s1_op = op_e'(s1_data[S1_W-1 -: 3]);

   // Re-pitch operands from WIDTH to the package's fixed MAX_W spacing.
   always_comb begin
      ops_pad = '0;
      for (int k = 0; k < N_IN; k++) begin
         ops_pad[k*MAX_W +: MAX_W] = MAX_W'(s1_data[k*WIDTH +: WIDTH]);
      end
   end

   assign res_full   = lgu_eval(s1_op, ops_pad, N_IN);
   assign unused_res = {1'b0, res_full};
   assign s2_in_data = {(s1_op == OP_ILL), res_full[WIDTH-1:0]};

   lgu_pipe_stage #(.DW(S2_W)) u_stage2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s1_valid),
      .in_ready  (s2_ready),
      .in_data   (s2_in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_data)
   );

   assign out_err  = s2_data[WIDTH];
   assign out_data = s2_data[WIDTH-1:0];

`ifdef LGU_STATS_EN
   logic [STAT_W-1:0] stat_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_cnt <= '0;
      end else if (out_valid && out_ready && (stat_cnt != '1)) begin
         stat_cnt <= stat_cnt + 1'b1;
      end
   end

   assign stat_ops = stat_cnt;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed and scoreboard bench for logic_gate_unit (N_IN=2 and N_IN=3 instances).
module tb_logic_gate_unit;
   import lgu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, out_err;
   logic [2:0]  in_op;
   logic [15:0] in_data;
   logic [7:0]  out_data;
   logic        in_valid_3, in_ready_3, out_valid_3, out_ready_3, out_err_3;
   logic [2:0]  in_op_3;
   logic [23:0] in_data_3;
   logic [7:0]  out_data_3;
`ifdef LGU_STATS_EN
   logic [31:0] stat_ops, stat_ops_3;
`endif

   int n_chk;
   int n_fail;

   logic_gate_unit #(.WIDTH(8), .N_IN(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
`ifdef LGU_STATS_EN
      , .stat_ops(stat_ops)
`endif
   );

   logic_gate_unit #(.WIDTH(8), .N_IN(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_3), .in_ready(in_ready_3),
      .in_op(in_op_3), .in_data(in_data_3), .out_valid(out_valid_3),
      .out_ready(out_ready_3), .out_data(out_data_3), .out_err(out_err_3)
`ifdef LGU_STATS_EN
      , .stat_ops(stat_ops_3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] model(input logic [2:0] op, input logic [15:0] d);
      logic [MAX_N*MAX_W-1:0] p;
      logic [MAX_W-1:0]       r;
      p = '0;
      p[7:0] = d[7:0];
      p[MAX_W +: 8] = d[15:8];
      r = lgu_eval(op_e'(op), p, 2);
      return {(op == 3'd7), r[7:0]};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; in_op = 3'd0; in_data = 16'hAA55;
      @(negedge clk);
      in_op = 3'd1; in_data = 16'h0F0F;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      n_chk++;
      if (out_data !== 8'h00 || out_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_data: got %h/%b want 00/0", out_data, out_err);
      end
`ifdef LGU_STATS_EN
      n_chk++;
      if (stat_ops !== 32'd0) begin
         n_fail++; $display("FAIL reset_stat_ops: got %0d want 0", stat_ops);
      end
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         n_chk++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_stale_beat: cycle %0d out_valid %b want 0", c, out_valid);
         end
      end
   endtask

   task automatic test_ops();
      logic [7:0] exp_res [7];
      exp_res = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F};
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i < 7) begin
            in_valid = 1'b1; in_op = 3'(i); in_data = 16'hCCF0;
         end else begin
            in_valid = 1'b0; in_op = 3'd7; in_data = 16'hFFFF;
         end
         #1;
         n_chk++;
         if (i < 2) begin
            if (out_valid !== 1'b0) begin
               n_fail++; $display("FAIL ops_latency: iter %0d out_valid %b want 0", i, out_valid);
            end
         end else if (out_valid !== 1'b1 || out_data !== exp_res[i-2] || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ops_op%0d: got v=%b d=%h e=%b want v=1 d=%h e=0",
                     i-2, out_valid, out_data, out_err, exp_res[i-2]);
         end
      end
   endtask

   task automatic test_n3();
      out_ready_3 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid_3 = (i < 2);
         in_op_3    = (i == 0) ? 3'd4 : 3'd7;
         in_data_3  = 24'h330FFF;
         #1;
         if (i == 2) begin
            n_chk++;
            if (out_valid_3 !== 1'b1 || out_data_3 !== 8'hC3 || out_err_3 !== 1'b0) begin
               n_fail++; $display("FAIL n3_xor: got v=%b d=%h e=%b want v=1 d=c3 e=0",
                                  out_valid_3, out_data_3, out_err_3);
            end
         end else if (i == 3) begin
            n_chk++;
            if (out_valid_3 !== 1'b1 || out_data_3 !== 8'h00 || out_err_3 !== 1'b1) begin
               n_fail++; $display("FAIL n3_illegal: got v=%b d=%h e=%b want v=1 d=00 e=1",
                                  out_valid_3, out_data_3, out_err_3);
            end
         end else if (i == 4) begin
            n_chk++;
            if (out_valid_3 !== 1'b0) begin
               n_fail++; $display("FAIL n3_drain: out_valid %b want 0", out_valid_3);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int acc;
      int rcv;
      acc = 0;
      rcv = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = 1'b1; in_op = 3'd1; in_data = {8'h00, 8'(8'h11 * (acc + 1))};
         #1;
         if (in_valid && in_ready) acc++;
         if (c >= 2) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== 8'h11) begin
               n_fail++; $display("FAIL bp_hold: cycle %0d got v=%b d=%h want v=1 d=11",
                                  c, out_valid, out_data);
            end
         end
      end
      n_chk++;
      if (acc != 2 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_accept: accepted %0d in_ready %b want 2 and 0", acc, in_ready);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         out_ready = 1'b1;
         #1;
         if (out_valid && out_ready) begin
            n_chk++;
            if (out_data !== 8'(8'h11 * (rcv + 1))) begin
               n_fail++; $display("FAIL bp_order: beat %0d got %h want %h",
                                  rcv, out_data, 8'(8'h11 * (rcv + 1)));
            end
            rcv++;
         end
      end
      n_chk++;
      if (rcv != 2) begin
         n_fail++; $display("FAIL bp_count: got %0d beats want 2", rcv);
      end
   endtask

   task automatic test_random();
      logic [8:0] sb [$];
      logic [8:0] exp_v;
      int sent;
      int rcv;
      int cyc;
      sent = 0;
      rcv = 0;
      cyc = 0;
      while (rcv < 1000 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (sent < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
         in_op     = 3'($urandom_range(0, 7));
         in_data   = 16'($urandom);
         #1;
         if (out_valid && out_ready) begin
            n_chk++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL rand_extra: unexpected beat d=%h", out_data);
            end else begin
               exp_v = sb.pop_front();
               if ({out_err, out_data} !== exp_v) begin
                  n_fail++; $display("FAIL rand_beat%0d: got e=%b d=%h want e=%b d=%h",
                                     rcv, out_err, out_data, exp_v[8], exp_v[7:0]);
               end
            end
            rcv++;
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(in_op, in_data));
            sent++;
         end
      end
      in_valid = 1'b0;
      n_chk++;
      if (rcv != 1000 || sb.size() != 0) begin
         n_fail++; $display("FAIL rand_complete: received %0d pending %0d want 1000 and 0",
                            rcv, sb.size());
      end
   endtask

`ifdef LGU_STATS_EN
   task automatic test_stats();
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 1004; c++) begin
         @(negedge clk);
         in_valid = (c < 1000);
         in_op = 3'd0; in_data = 16'h1234;
      end
      #1;
      n_chk++;
      if (stat_ops !== 32'd1000) begin
         n_fail++; $display("FAIL stats_count: got %0d want 1000", stat_ops);
      end
      force dut.stat_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.stat_cnt;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         in_valid = (c == 0);
      end
      #1;
      n_chk++;
      if (stat_ops !== 32'hFFFF_FFFF) begin
         n_fail++; $display("FAIL stats_saturate: got %h want ffffffff", stat_ops);
      end
   endtask
`endif

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      in_valid = 1'b0; in_op = 3'd0; in_data = '0; out_ready = 1'b1;
      in_valid_3 = 1'b0; in_op_3 = 3'd0; in_data_3 = '0; out_ready_3 = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_ops();
      test_n3();
      test_backpressure();
      test_random();
`ifdef LGU_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
